// File: rtl/pulse_seq_pkg.sv
// rtl/pulse_seq_pkg.sv - shared types and constants for pulse_sequencer
// Purpose: FSM state encoding, field widths and the ms-to-cycles helper.
// Ports: none (package).
package pulse_seq_pkg;

  localparam int DUR_W = 8;  // width of one dur_ms slice
  localparam int ID_W  = 3;  // width of grant_id / round-robin pointer

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } state_t;

  function automatic int unsigned cyc_per_ms(input longint unsigned clk_hz);
    return int'(clk_hz / 1000);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick over pending requests
// Purpose: pick the first set bit of pending searching from pointer+1 with wrap.
// Ports:
//   pending  in  N_REQ  requests waiting for service
//   pointer  in  ID_W   index served last
//   grant    out N_REQ  one-hot pick (all zero when pending == 0)
//   index    out ID_W   binary index of the pick (0 when pending == 0)
module rr_arbiter
  import pulse_seq_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0] pending,
  input  logic [ID_W-1:0]  pointer,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  index
);

  logic found;
  int   cand;

  always_comb begin
    grant = '0;
    index = '0;
    found = 1'b0;
    cand  = 0;
    // offsets 1..N_REQ so the last served requester is checked last
    for (int off = 1; off <= N_REQ; off++) begin
      cand = int'(pointer) + off;
      if (cand >= N_REQ) cand = cand - N_REQ;
      if (!found && pending[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        index       = ID_W'(cand);
      end
    end
  end

endmodule

// File: rtl/pulse_sequencer.sv
// rtl/pulse_sequencer.sv - round-robin sharing of one timed pulse output
// Purpose: latch rising edges on req_in, serve them one at a time with a
//   pulse of dur_ms[i] ms followed by a GAP_MS guard gap.
// Optional feature: PULSE_SEQ_DROP_CNT_EN adds drop_cnt (absorbed-edge counter).
// Ports:
//   clk        in   1          clock
//   rstn       in   1          synchronous active-low reset
//   req_in     in   N_REQ      request lines, rising edge = request
//   dur_ms     in   8*N_REQ    pulse length per requester in ms
//   pulse_out  out  1          shared pulse output
//   grant_id   out  3          requester being served, valid while busy
//   busy       out  1          high in PULSE and GAP
//   pending    out  N_REQ      latched, not yet served requests
//   drop_cnt   out  16         absorbed edges, saturating (optional)
module pulse_sequencer
  import pulse_seq_pkg::*;
#(
  parameter int CLK_HZ = 27000000,
  parameter int N_REQ  = 4,
  parameter int GAP_MS = 1
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [N_REQ-1:0]       req_in,
  input  logic [DUR_W*N_REQ-1:0] dur_ms,
  output logic                   pulse_out,
  output logic [ID_W-1:0]        grant_id,
  output logic                   busy,
`ifdef PULSE_SEQ_DROP_CNT_EN
  output logic [15:0]            drop_cnt,
`endif
  output logic [N_REQ-1:0]       pending
);

  localparam int unsigned CYC_PER_MS = cyc_per_ms(longint'(CLK_HZ));
  localparam logic [31:0] GAP_CYC    = 32'(GAP_MS * CYC_PER_MS);

  if (N_REQ < 2 || N_REQ > 8) begin : g_bad_nreq
    $error("pulse_sequencer: N_REQ must be 2..8");
  end
  if (64'(CYC_PER_MS) * 64'd255 >= 64'h1_0000_0000) begin : g_bad_clk
    $error("pulse_sequencer: 255*CYC_PER_MS does not fit in 32 bits");
  end

  state_t            state, state_nxt;
  logic [N_REQ-1:0]  req_d;
  logic [N_REQ-1:0]  rise;
  logic [N_REQ-1:0]  grant_oh;
  logic [N_REQ-1:0]  grant_clr;
  logic [ID_W-1:0]   pick_idx;
  logic [ID_W-1:0]   pointer;
  logic [31:0]       counter;
  logic [31:0]       limit;
  logic [31:0]       limit_pick;
  logic [DUR_W-1:0]  dur_pick;
  logic              take;
  logic              last_pulse;
  logic              last_gap;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .pending (pending),
    .pointer (pointer),
    .grant   (grant_oh),
    .index   (pick_idx)
  );

  assign rise       = req_in & ~req_d;
  assign take       = (state == IDLE) && (|pending);
  assign grant_clr  = take ? grant_oh : '0;
  assign dur_pick   = dur_ms[DUR_W*int'(pick_idx) +: DUR_W];
  assign limit_pick = 32'((dur_pick == '0) ? DUR_W'(1) : dur_pick) * CYC_PER_MS;
  assign last_pulse = (counter == limit - 32'd1);
  assign last_gap   = (counter == GAP_CYC - 32'd1);

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  // FSM next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (take) state_nxt = PULSE;
      PULSE:   if (last_pulse) state_nxt = (GAP_MS == 0) ? IDLE : GAP;
      GAP:     if (last_gap) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    pulse_out = (state == PULSE);
    busy      = (state != IDLE);
  end

  // Edge history, pending set, grant bookkeeping and the shared counter.
  // A rise on the index being granted re-arms pending because rise is OR-ed
  // after the clear.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      req_d    <= '0;
      pending  <= '0;
      pointer  <= ID_W'(N_REQ - 1);
      grant_id <= '0;
      counter  <= '0;
      limit    <= '0;
    end else begin
      req_d   <= req_in;
      pending <= (pending & ~grant_clr) | rise;
      case (state)
        IDLE: begin
          if (take) begin
            grant_id <= pick_idx;
            pointer  <= pick_idx;
            limit    <= limit_pick;
            counter  <= '0;
          end
        end
        PULSE:   counter <= last_pulse ? 32'd0 : counter + 32'd1;
        GAP:     counter <= counter + 32'd1;
        default: counter <= '0;
      endcase
    end
  end

`ifdef PULSE_SEQ_DROP_CNT_EN
  logic [N_REQ-1:0] absorbed;
  logic [3:0]       n_abs;
  logic [16:0]      drop_sum;

  assign absorbed = rise & pending & ~grant_clr;

  always_comb begin
    n_abs = '0;
    for (int i = 0; i < N_REQ; i++) n_abs = n_abs + 4'(absorbed[i]);
    drop_sum = {1'b0, drop_cnt} + 17'(n_abs);
  end

  always_ff @(posedge clk) begin
    if (!rstn)            drop_cnt <= '0;
    else if (drop_sum[16]) drop_cnt <= 16'hFFFF;
    else                  drop_cnt <= drop_sum[15:0];
  end
`endif

endmodule

// File: tb/tb_pulse_sequencer.sv
// tb/tb_pulse_sequencer.sv - directed self-checking bench for pulse_sequencer
module tb_pulse_sequencer;

  logic        clk = 1'b0;
  logic        rstn;
  logic [3:0]  req_in;
  logic [31:0] dur_ms;
  logic        pulse_out;
  logic [2:0]  grant_id;
  logic        busy;
  logic [3:0]  pending;
  logic [3:0]  req_g0;
  logic [31:0] dur_g0;
  logic        pulse_g0;
  logic [2:0]  grant_g0;
  logic        busy_g0;
  logic [3:0]  pending_g0;
`ifdef PULSE_SEQ_DROP_CNT_EN
  logic [15:0] drop_cnt;
  logic [15:0] drop_g0;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pulse_sequencer #(.CLK_HZ(10000), .N_REQ(4), .GAP_MS(1)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .req_in    (req_in),
    .dur_ms    (dur_ms),
    .pulse_out (pulse_out),
    .grant_id  (grant_id),
    .busy      (busy),
`ifdef PULSE_SEQ_DROP_CNT_EN
    .drop_cnt  (drop_cnt),
`endif
    .pending   (pending)
  );

  pulse_sequencer #(.CLK_HZ(10000), .N_REQ(4), .GAP_MS(0)) dut_g0 (
    .clk       (clk),
    .rstn      (rstn),
    .req_in    (req_g0),
    .dur_ms    (dur_g0),
    .pulse_out (pulse_g0),
    .grant_id  (grant_g0),
    .busy      (busy_g0),
`ifdef PULSE_SEQ_DROP_CNT_EN
    .drop_cnt  (drop_g0),
`endif
    .pending   (pending_g0)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rstn   = 1'b0;
    req_in = '0;
    req_g0 = '0;
    step();
    step();
    rstn = 1'b1;
    step();
  endtask

  task automatic wait_pulse(input string tag);
    int n = 0;
    while (!pulse_out && n < 200) begin
      step();
      n++;
    end
    chk(tag, 32'(pulse_out), 32'd1);
  endtask

  task automatic wait_low();
    int n = 0;
    while (pulse_out && n < 2000) begin
      step();
      n++;
    end
  endtask

  // Called with pulse_out currently high; returns high and gap sample counts.
  task automatic measure(output int hi, output int gap);
    hi  = 0;
    gap = 0;
    while (pulse_out && hi < 2000) begin
      hi++;
      step();
    end
    while (busy && !pulse_out && gap < 2000) begin
      gap++;
      step();
    end
  endtask

  task automatic count_idle(output int idle);
    idle = 0;
    while (!pulse_out && idle < 200) begin
      idle++;
      step();
    end
  endtask

  int hi, gap, idle, n;
  logic [2:0] order [3];

  initial begin
    dur_ms = {8'd1, 8'd1, 8'd1, 8'd1};
    dur_g0 = {8'd1, 8'd1, 8'd1, 8'd1};
    do_reset();

    // reset state
    chk("rst_pulse",   32'(pulse_out), 32'd0);
    chk("rst_busy",    32'(busy),      32'd0);
    chk("rst_pending", 32'(pending),   32'd0);
    chk("rst_grant",   32'(grant_id),  32'd0);
`ifdef PULSE_SEQ_DROP_CNT_EN
    chk("rst_drop",    32'(drop_cnt),  32'd0);
`endif

    // 1. single request, dur=3 ms -> 2-cycle latency, 30 high, 10 gap
    dur_ms[23:16] = 8'd3;
    req_in[2] = 1'b1;
    step();
    chk("t1_pending",   32'(pending),   32'b0100);
    chk("t1_lat1",      32'(pulse_out), 32'd0);
    step();
    chk("t1_lat2",      32'(pulse_out), 32'd1);
    chk("t1_grant",     32'(grant_id),  32'd2);
    chk("t1_busy",      32'(busy),      32'd1);
    measure(hi, gap);
    chk("t1_width",     32'(hi),        32'd30);
    chk("t1_gap",       32'(gap),       32'd10);
    chk("t1_idle_busy", 32'(busy),      32'd0);

    // 2. contention on 0,1,3 -> order 0,1,3, 10 gap + 1 idle between
    do_reset();
    dur_ms = {8'd1, 8'd1, 8'd1, 8'd1};
    req_in = 4'b1011;
    step();
    step();
    order[0] = 3'd0;
    order[1] = 3'd1;
    order[2] = 3'd3;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("t2_grant%0d", k), 32'(grant_id), 32'(order[k]));
      measure(hi, gap);
      chk($sformatf("t2_width%0d", k), 32'(hi),  32'd10);
      chk($sformatf("t2_gap%0d", k),   32'(gap), 32'd10);
      if (k < 2) begin
        count_idle(idle);
        chk($sformatf("t2_idle%0d", k), 32'(idle), 32'd1);
      end
    end
    chk("t2_done", 32'(busy), 32'd0);

    // 3. fairness: req 0 re-rises every pulse, req 1 once -> 0,1,0
    do_reset();
    order[0] = 3'd0;
    order[1] = 3'd1;
    order[2] = 3'd0;
    req_in[0] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_pulse($sformatf("t3_seen%0d", k));
      chk($sformatf("t3_grant%0d", k), 32'(grant_id), 32'(order[k]));
      req_in[0] = 1'b0;
      step();
      req_in[0] = 1'b1;
      if (k == 0) req_in[1] = 1'b1;
      step();
      wait_low();
    end

    // 4. absorb: req 1 rises twice while pending behind a req 2 pulse
    do_reset();
    req_in[2] = 1'b1;
    step();
    step();
    chk("t4_first", 32'(grant_id), 32'd2);
    req_in[1] = 1'b1;
    step();
    req_in[1] = 1'b0;
    step();
    req_in[1] = 1'b1;
    step();
    chk("t4_pending", 32'(pending), 32'b0010);
`ifdef PULSE_SEQ_DROP_CNT_EN
    chk("t4_drop", 32'(drop_cnt), 32'd1);
`endif
    wait_low();
    wait_pulse("t4_seen");
    chk("t4_grant", 32'(grant_id), 32'd1);
    wait_low();
    n = 0;
    for (int c = 0; c < 40; c++) begin
      if (pulse_out) n++;
      step();
    end
    chk("t4_extra", 32'(n), 32'd0);

    // 5. reset at cycle 5 of a pulse, with req 3 pending
    do_reset();
    dur_ms[7:0] = 8'd2;
    req_in[0] = 1'b1;
    step();
    step();
    req_in[3] = 1'b1;
    step();
    step();
    step();
    step();
    chk("t5_mid", 32'(pulse_out), 32'd1);
    rstn   = 1'b0;
    req_in = '0;
    step();
    chk("t5_pulse",   32'(pulse_out), 32'd0);
    chk("t5_pending", 32'(pending),   32'd0);
    chk("t5_busy",    32'(busy),      32'd0);
    rstn = 1'b1;
    step();
    req_in[1] = 1'b1;
    step();
    step();
    chk("t5_after", 32'(pulse_out), 32'd1);
    chk("t5_grant", 32'(grant_id),  32'd1);
    measure(hi, gap);
    chk("t5_width", 32'(hi), 32'd10);

    // 6a. dur_ms=0 treated as 1 ms
    do_reset();
    dur_ms[31:24] = 8'd0;
    req_in[3] = 1'b1;
    step();
    step();
    chk("t6_zero_grant", 32'(grant_id), 32'd3);
    measure(hi, gap);
    chk("t6_zero_width", 32'(hi), 32'd10);

    // 6b. dur_ms change mid-pulse does not alter length
    do_reset();
    dur_ms[7:0] = 8'd2;
    req_in[0] = 1'b1;
    step();
    step();
    dur_ms[7:0] = 8'd5;
    measure(hi, gap);
    chk("t6_chg_width", 32'(hi), 32'd20);

    // 6c. GAP_MS=0 build: PULSE -> IDLE, then one idle cycle before next pulse
    do_reset();
    req_g0 = 4'b0011;
    step();
    step();
    chk("t6_g0_grant0", 32'(grant_g0), 32'd0);
    hi = 0;
    while (pulse_g0 && hi < 200) begin
      hi++;
      step();
    end
    chk("t6_g0_width", 32'(hi),      32'd10);
    chk("t6_g0_busy",  32'(busy_g0), 32'd0);
    step();
    chk("t6_g0_next",   32'(pulse_g0), 32'd1);
    chk("t6_g0_grant1", 32'(grant_g0), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
